// File: rtl/square_wave_analyzer_if.sv
// Square wave analyzer bus: wave input and measurement result outputs.
// master drives wave_in and observes results; slave is the analyzer.
interface square_wave_analyzer_if #(
    parameter int CNT_W = 4
);
    logic             wave_in;
    logic [CNT_W-1:0] m_out;
    logic [CNT_W-1:0] n_out;
    logic             valid;
    logic             sat;
    logic             err;

    modport master (
        output wave_in,
        input  m_out, n_out, valid, sat, err
    );

    modport slave (
        input  wave_in,
        output m_out, n_out, valid, sat, err
    );
endinterface

// File: rtl/square_wave_analyzer.sv
// Measures HIGH/LOW phase widths of an async square wave in TICK_DIV units.
// Ports: clk, clr_n (async low), bus.slave (wave_in -> m_out/n_out/valid/sat/err).
module square_wave_analyzer #(
    parameter int TICK_DIV = 5,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  clr_n,
    square_wave_analyzer_if.slave bus
);
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HALF = TICK_DIV / 2;
    localparam int INIT = 1 + HALF;

    // Counter holds (X + HALF) split as u*TICK_DIV + p, so u is
    // already the rounded width; it is seeded for X = 1.
    localparam logic [PW-1:0]  P_INIT = PW'(INIT % TICK_DIV);
    localparam logic [CNT_W:0] U_INIT = (CNT_W+1)'(INIT / TICK_DIV);
    localparam logic [PW-1:0]  P_LAST = PW'(TICK_DIV - 1);
    // X == 2^CNT_W * TICK_DIV maps to u = 2^CNT_W, p = HALF.
    localparam logic [CNT_W:0] U_TO   = (CNT_W+1)'(1 << CNT_W);
    localparam logic [PW-1:0]  P_TO   = PW'(HALF);
    localparam logic [CNT_W-1:0] MAXV = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [PW-1:0]    p_q, p_d;
    logic [CNT_W:0]   u_q, u_d;
    logic [CNT_W-1:0] m_hold_q, m_hold_d;
    logic             m_sat_q, m_sat_d;
    logic [CNT_W-1:0] m_out_q, m_out_d;
    logic [CNT_W-1:0] n_out_q, n_out_d;
    logic             sat_q, sat_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic             rise;
    logic             fall;
    logic             tmo;
    logic [PW-1:0]    p_inc;
    logic [CNT_W:0]   u_inc;
    logic [CNT_W:0]   rnd;

    // Bit CNT_W of u can only be set at exactly 2^CNT_W: clamp + sat.
    assign rnd   = u_q[CNT_W] ? {1'b1, MAXV} : {1'b0, u_q[CNT_W-1:0]};
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;
    assign tmo   = (u_q == U_TO) && (p_q == P_TO);
    assign p_inc = (p_q == P_LAST) ? '0 : p_q + 1'b1;
    assign u_inc = (p_q == P_LAST) ? u_q + 1'b1 : u_q;

    always_comb begin
        state_d  = state_q;
        s1_d     = bus.wave_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        p_d      = p_q;
        u_d      = u_q;
        m_hold_d = m_hold_q;
        m_sat_d  = m_sat_q;
        m_out_d  = m_out_q;
        n_out_d  = n_out_q;
        sat_d    = sat_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    u_d     = U_INIT;
                    p_d     = P_INIT;
                end
            end
            HIGH: begin
                if (fall) begin
                    m_hold_d = rnd[CNT_W-1:0];
                    m_sat_d  = rnd[CNT_W];
                    state_d  = LOW;
                    u_d      = U_INIT;
                    p_d      = P_INIT;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    u_d = u_inc;
                    p_d = p_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    m_out_d = m_hold_q;
                    n_out_d = rnd[CNT_W-1:0];
                    sat_d   = m_sat_q | rnd[CNT_W];
                    valid_d = 1'b1;
                    state_d = HIGH;
                    u_d     = U_INIT;
                    p_d     = P_INIT;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    u_d = u_inc;
                    p_d = p_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            p_q      <= '0;
            u_q      <= '0;
            m_hold_q <= '0;
            m_sat_q  <= 1'b0;
            m_out_q  <= '0;
            n_out_q  <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            p_q      <= p_d;
            u_q      <= u_d;
            m_hold_q <= m_hold_d;
            m_sat_q  <= m_sat_d;
            m_out_q  <= m_out_d;
            n_out_q  <= n_out_d;
            sat_q    <= sat_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign bus.m_out = m_out_q;
    assign bus.n_out = n_out_q;
    assign bus.sat   = sat_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_square_wave_analyzer.sv
// Bench for square_wave_analyzer: phase-level model plus literal checks.
// Drives wave_in as (level, length) phases and checks outputs each cycle.
module tb_square_wave_analyzer;
    localparam int TD    = 5;
    localparam int CW    = 4;
    localparam int MAXV  = (1 << CW) - 1;
    localparam int LIMIT = (1 << CW) * TD;

    typedef struct {
        int at;
        bit is_err;
        int m;
        int n;
        bit sat;
    } ev_t;

    logic clk;
    logic clr_n;
    int   cyc;
    int   total;
    int   bad;

    ev_t  q[$];
    int   exp_m;
    int   exp_n;
    bit   exp_sat;
    int   mst;
    int   hi_len;
    int   lo_len;

    int   n_valid;
    int   n_err;
    int   last_err;
    int   last_valid;
    int   vgap;

    square_wave_analyzer_if #(.CNT_W(CW)) bus ();

    square_wave_analyzer #(
        .TICK_DIV(TD),
        .CNT_W   (CW)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int raw(input int x);
        return (x + TD / 2) / TD;
    endfunction

    function automatic int rval(input int x);
        return (raw(x) > MAXV) ? MAXV : raw(x);
    endfunction

    function automatic bit rsat(input int x);
        return raw(x) > MAXV;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)",
                     nm, act, req, cyc);
        end
    endtask

    // Phase-level model: a rise is seen 3 edges after wave_in changes;
    // a phase longer than LIMIT clocks times out LIMIT edges later.
    task automatic phase(input bit lvl, input int len);
        int  d;
        ev_t e;
        d = cyc + 3;
        bus.wave_in = lvl;
        if (lvl) begin
            if (mst == 2) begin
                e.at = d;
                e.is_err = 1'b0;
                e.m = rval(hi_len);
                e.n = rval(lo_len);
                e.sat = rsat(hi_len) | rsat(lo_len);
                q.push_back(e);
            end
            if (len > LIMIT) begin
                e = '{at: d + LIMIT, is_err: 1'b1, m: 0, n: 0, sat: 1'b0};
                q.push_back(e);
                mst = 0;
            end else begin
                hi_len = len;
                mst = 1;
            end
        end else if (mst == 1) begin
            if (len > LIMIT) begin
                e = '{at: d + LIMIT, is_err: 1'b1, m: 0, n: 0, sat: 1'b0};
                q.push_back(e);
                mst = 0;
            end else begin
                lo_len = len;
                mst = 2;
            end
        end
        repeat (len) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        clr_n = 1'b0;
        mst = 0;
        q.delete();
        exp_m = 0;
        exp_n = 0;
        exp_sat = 1'b0;
        #2;
        chk("arst_m", int'(bus.m_out), 0);
        chk("arst_n", int'(bus.n_out), 0);
        chk("arst_sat", int'(bus.sat), 0);
        chk("arst_valid", int'(bus.valid), 0);
        chk("arst_err", int'(bus.err), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        clr_n = 1'b1;
    endtask

    always @(negedge clk) begin
        ev_t e;
        bit  here;
        bit  ev_v;
        bit  ev_e;
        while (q.size() > 0 && q[0].at < cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missed_event: got none want at cyc %0d", e.at);
        end
        here = (q.size() > 0) && (q[0].at == cyc);
        ev_v = 1'b0;
        ev_e = 1'b0;
        if (here) begin
            e = q.pop_front();
            ev_e = e.is_err;
            ev_v = !e.is_err;
            if (ev_v) begin
                exp_m = e.m;
                exp_n = e.n;
                exp_sat = e.sat;
            end
        end
        chk("valid", int'(bus.valid), int'(ev_v));
        chk("err", int'(bus.err), int'(ev_e));
        chk("m_out", int'(bus.m_out), exp_m);
        chk("n_out", int'(bus.n_out), exp_n);
        chk("sat", int'(bus.sat), int'(exp_sat));
        if (bus.valid) begin
            n_valid++;
            vgap = cyc - last_valid;
            last_valid = cyc;
        end
        if (bus.err) begin
            n_err++;
            last_err = cyc;
        end
    end

    initial begin
        int nv0;
        int ne0;
        int s;
        total = 0;
        bad = 0;
        exp_m = 0;
        exp_n = 0;
        exp_sat = 1'b0;
        mst = 0;
        hi_len = 0;
        lo_len = 0;
        n_valid = 0;
        n_err = 0;
        last_err = 0;
        last_valid = 0;
        vgap = 0;
        bus.wave_in = 1'b0;
        clr_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_m", int'(bus.m_out), 0);
        chk("rst_n", int'(bus.n_out), 0);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_err", int'(bus.err), 0);
        clr_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        // 15 high / 10 low, four periods
        nv0 = n_valid;
        ne0 = n_err;
        phase(1'b1, 15);
        phase(1'b0, 10);
        chk("t1_no_early_valid", n_valid - nv0, 0);
        for (int i = 0; i < 3; i++) begin
            phase(1'b1, 15);
            phase(1'b0, (i == 2) ? 100 : 10);
        end
        chk("t1_valids", n_valid - nv0, 3);
        chk("t1_errs", n_err - ne0, 1);
        chk("t1_gap", vgap, 25);
        chk("t1_m", int'(bus.m_out), 3);
        chk("t1_n", int'(bus.n_out), 2);
        chk("t1_sat", int'(bus.sat), 0);

        // 12/13 then 2/10
        phase(1'b1, 12);
        phase(1'b0, 13);
        phase(1'b1, 2);
        phase(1'b0, 10);
        chk("t2a_m", int'(bus.m_out), 2);
        chk("t2a_n", int'(bus.n_out), 3);
        phase(1'b1, 10);
        phase(1'b0, 100);
        chk("t2b_m", int'(bus.m_out), 0);
        chk("t2b_n", int'(bus.n_out), 2);

        // 78/5 saturates, then 10/10
        phase(1'b1, 78);
        phase(1'b0, 5);
        phase(1'b1, 10);
        phase(1'b0, 10);
        chk("t3a_m", int'(bus.m_out), 15);
        chk("t3a_n", int'(bus.n_out), 1);
        chk("t3a_sat", int'(bus.sat), 1);
        phase(1'b1, 10);
        phase(1'b0, 100);
        chk("t3b_m", int'(bus.m_out), 2);
        chk("t3b_n", int'(bus.n_out), 2);
        chk("t3b_sat", int'(bus.sat), 0);

        // stuck high -> one err, then recovery
        nv0 = n_valid;
        ne0 = n_err;
        s = cyc;
        phase(1'b1, 200);
        chk("t4_errs", n_err - ne0, 1);
        chk("t4_err_lat", last_err - (s + 3), 80);
        chk("t4_no_valid", n_valid - nv0, 0);
        phase(1'b0, 10);
        phase(1'b1, 10);
        phase(1'b0, 10);
        chk("t4_still_quiet", n_valid - nv0, 0);
        phase(1'b1, 10);
        phase(1'b0, 100);
        chk("t4_resume", n_valid - nv0, 1);
        chk("t4_m", int'(bus.m_out), 2);

        // reset mid-LOW
        phase(1'b1, 15);
        phase(1'b0, 10);
        phase(1'b1, 15);
        phase(1'b0, 6);
        pulse_reset();
        nv0 = n_valid;
        phase(1'b0, 10);
        phase(1'b1, 15);
        phase(1'b0, 10);
        chk("t5_no_valid", n_valid - nv0, 0);
        phase(1'b1, 15);
        chk("t5_first_valid", n_valid - nv0, 1);
        chk("t5_m", int'(bus.m_out), 3);
        chk("t5_n", int'(bus.n_out), 2);
        phase(1'b0, 10);
        phase(1'b1, 10);
        phase(1'b0, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
